// File: rtl/mult_operand_sequencer.sv
// Valid/ready operand/product register wrapper around a combinational 4x4 multiplier.
// Optional accumulator on completed products is enabled with `define MULT_SEQ_ACCUM_EN.
module mult_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [3:0]  mult_m,
  output logic [3:0]  mult_q,
  input  logic [7:0]  mult_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic [7:0]  done_count
`ifdef MULT_SEQ_ACCUM_EN
  ,
  input  logic        acc_clr,
  output logic [11:0] acc_out
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] done_q, done_d;
  logic       accept;
  logic       handshake;

  // HOLD can accept only when the held product leaves on the same edge.
  assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_d         = m_q;
    q_d         = q_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          m_d     = in_data[3:0];
          q_d     = in_data[7:4];
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_data_d  = mult_p;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          done_d      = done_q + 8'd1;
          out_valid_d = 1'b0;
          if (accept) begin
            m_d     = in_data[3:0];
            q_d     = in_data[7:4];
            cnt_d   = CNT_INIT;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      m_q         <= '0;
      q_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_q         <= m_d;
      q_q         <= q_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign mult_m     = m_q;
  assign mult_q     = q_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign done_count = done_q;
  assign busy       = (state_q != IDLE);

`ifdef MULT_SEQ_ACCUM_EN
  logic [11:0] acc_q, acc_d;

  // Clear coinciding with a handshake restarts the sum at the current product.
  always_comb begin
    acc_d = acc_q;
    if (handshake) begin
      acc_d = acc_clr ? {4'b0000, out_data_q} : acc_q + {4'b0000, out_data_q};
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;
`endif

endmodule
